// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-chunk adder/subtractor. Each stage adds one CHUNK-bit slice
// and registers that slice's sum and carry. It also forwards the operands and
// the partial sum, so every transaction moves through the stages as one unit.
// All stages shift together when the output slot is free or is being drained.
// WIDTH must be a multiple of CHUNK.

module pca_stage #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int K     = 0
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             adv,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             c_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o,
  output logic             ovf_o
);
  localparam int LO = K * CHUNK;

  logic [CHUNK:0]   part;
  logic             cmsb;
  logic [WIDTH-1:0] sum_n;

  // Slice add. Carry into the slice's top bit is recovered as sum^a^b at that bit.
  always_comb begin
    part  = {1'b0, a_i[LO +: CHUNK]} + {1'b0, b_i[LO +: CHUNK]} + {{CHUNK{1'b0}}, c_i};
    cmsb  = part[CHUNK-1] ^ a_i[LO+CHUNK-1] ^ b_i[LO+CHUNK-1];
    sum_n = sum_i;
    sum_n[LO +: CHUNK] = part[CHUNK-1:0];
  end

  // Stage register: shift on advance, hold otherwise. The last stage's ovf is the block's ovf.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      vld_o <= 1'b0;
      a_o   <= '0;
      b_o   <= '0;
      sum_o <= '0;
      c_o   <= 1'b0;
      ovf_o <= 1'b0;
    end else if (adv) begin
      vld_o <= vld_i;
      a_o   <= a_i;
      b_o   <= b_i;
      sum_o <= sum_n;
      c_o   <= part[CHUNK];
      ovf_o <= cmsb ^ part[CHUNK];
    end
  end
endmodule

module pipelined_carry_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;

  logic                        adv;
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0]             c_pipe;
  logic [STAGES:1]             ovf_pipe;
  logic [STAGES:0][WIDTH-1:0]  a_pipe;
  logic [STAGES:0][WIDTH-1:0]  b_pipe;
  logic [STAGES:0][WIDTH-1:0]  sum_pipe;
  logic                        unused;

  // Whole pipe moves whenever the output register is empty or being taken.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Entry: subtract is x + ~y + 1, so cin is overridden in sub mode.
  assign vld_pipe[0] = in_valid;
  assign a_pipe[0]   = x;
  assign b_pipe[0]   = sub ? ~y : y;
  assign c_pipe[0]   = sub | cin;
  assign sum_pipe[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    pca_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .K(k)) u_stg (
      .gclk   (Clk),
      .grst_n (Reset_n),
      .adv    (adv),
      .vld_i  (vld_pipe[k]),
      .a_i    (a_pipe[k]),
      .b_i    (b_pipe[k]),
      .sum_i  (sum_pipe[k]),
      .c_i    (c_pipe[k]),
      .vld_o  (vld_pipe[k+1]),
      .a_o    (a_pipe[k+1]),
      .b_o    (b_pipe[k+1]),
      .sum_o  (sum_pipe[k+1]),
      .c_o    (c_pipe[k+1]),
      .ovf_o  (ovf_pipe[k+1])
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign s         = sum_pipe[STAGES];
  assign cout      = c_pipe[STAGES];
  assign ovf       = ovf_pipe[STAGES];

  // Operands past the last stage and intermediate slice ovf flags have no consumer.
  assign unused = ^{a_pipe[STAGES], b_pipe[STAGES], ovf_pipe};
endmodule
